// File: rtl/reset_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_if
// Brief    : Pin bundle between the reset sequencer and the domains it releases.
// Revision : 1.0 - initial release
// ============================================================================
interface reset_seq_if #(
    parameter int NOUT   = 3,
    parameter int NREADY = 1
);
    logic              key_n;
    logic [NREADY-1:0] ready;
    logic [NOUT-1:0]   n_reset_out;
    logic              busy;
    logic              timeout;

    modport master (
        input  key_n,
        input  ready,
        output n_reset_out,
        output busy,
        output timeout
    );

    modport slave (
        output key_n,
        output ready,
        input  n_reset_out,
        input  busy,
        input  timeout
    );
endinterface
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq
// Brief    : Debounced, ready-gated staged reset release for the clkSYS domain.
//            Define RESET_SEQ_WDT_EN to build the WAIT_RDY watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module reset_seq #(
    parameter int NOUT      = 3,
    parameter int NREADY    = 1,
    parameter int DEB_CYC   = 16,
    parameter int HOLD_CYC  = 1000,
    parameter int STAGE_CYC = 16,
    parameter int WDT_CYC   = 1000000
) (
    input wire          clkSYS,
    input wire          n_reset,
    reset_seq_if.master bus
);
    localparam int c_CNT_MAX = ((HOLD_CYC > STAGE_CYC) ? HOLD_CYC : STAGE_CYC) - 1;
    localparam int c_CNT_W   = (c_CNT_MAX > 0) ? $clog2(c_CNT_MAX + 1) : 1;
    localparam int c_DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STAGE_LAST = c_CNT_W'(STAGE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_DEB_W-1:0] c_DEB_LOAD   = c_DEB_W'(DEB_CYC - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE    = c_DEB_W'(1);
    localparam logic [NOUT-1:0]    c_OUT_MEM    = NOUT'(1);
    localparam logic [NOUT-1:0]    c_OUT_FIRST2 = NOUT'(3);

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_HOLD     = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_STAGE    = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_key_s1, r_key_s2, r_key_deb;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [NREADY-1:0]   r_rdy_s1, r_rdy_s2;
    logic                w_rdy_all;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [NOUT-1:0]     r_out, w_out_nxt;
    logic                r_busy;

`ifdef RESET_SEQ_WDT_EN
    localparam int                 c_WDT_W    = (WDT_CYC > 1) ? $clog2(WDT_CYC) : 1;
    localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(WDT_CYC - 1);
    localparam logic [c_WDT_W-1:0] c_WDT_ONE  = c_WDT_W'(1);

    logic [c_WDT_W-1:0] r_wdt, w_wdt_nxt;
    logic               r_timeout, w_timeout_nxt;
`endif

    assign w_rdy_all = &r_rdy_s2;

    // Key syncs to "released" so the first sequence starts without a debounce wait.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_key_s1  <= 1'b1;
            r_key_s2  <= 1'b1;
            r_key_deb <= 1'b1;
            r_deb_cnt <= c_DEB_LOAD;
            r_rdy_s1  <= '0;
            r_rdy_s2  <= '0;
        end else begin
            r_key_s1 <= bus.key_n;
            r_key_s2 <= r_key_s1;
            r_rdy_s1 <= bus.ready;
            r_rdy_s2 <= r_rdy_s1;
            if (r_key_s2 == r_key_deb) begin
                r_deb_cnt <= c_DEB_LOAD;
            end else if (r_deb_cnt == '0) begin
                r_key_deb <= r_key_s2;
                r_deb_cnt <= c_DEB_LOAD;
            end else begin
                r_deb_cnt <= r_deb_cnt - c_DEB_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_cnt_nxt   = '0;
`ifdef RESET_SEQ_WDT_EN
        w_wdt_nxt     = '0;
        w_timeout_nxt = r_timeout;
`endif
        if (!r_key_deb) begin
            // A debounced press outranks everything, including a same-edge ready rise.
            w_state_nxt = S_RESET;
            w_out_nxt   = '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    w_state_nxt = S_HOLD;
                    w_out_nxt   = '0;
                end
                S_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_state_nxt = S_WAIT_RDY;
                        w_out_nxt   = c_OUT_MEM;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_WAIT_RDY: begin
                    if (w_rdy_all) begin
                        w_out_nxt   = c_OUT_FIRST2;
                        w_state_nxt = (NOUT == 2) ? S_RUN : S_STAGE;
                    end
`ifdef RESET_SEQ_WDT_EN
                    else if (r_wdt == c_WDT_LAST) begin
                        w_state_nxt   = S_RESET;
                        w_out_nxt     = '0;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_wdt_nxt = r_wdt + c_WDT_ONE;
                    end
`endif
                end
                S_STAGE: begin
                    if (!w_rdy_all) begin
                        w_state_nxt = S_WAIT_RDY;
                        w_out_nxt   = r_out & c_OUT_MEM;
                    end else if (r_cnt == c_STAGE_LAST) begin
                        // Outputs are a thermometer code: shifting in a 1 releases the next domain.
                        w_out_nxt = {r_out[NOUT-2:0], 1'b1};
                        if (r_out[NOUT-2]) begin
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!w_rdy_all) begin
                        w_state_nxt = S_WAIT_RDY;
                        w_out_nxt   = r_out & c_OUT_MEM;
                    end
                end
                default: begin
                    w_state_nxt = S_RESET;
                    w_out_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_RESET;
            r_out   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_RUN);
        end
    end

`ifdef RESET_SEQ_WDT_EN
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_wdt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdt     <= w_wdt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = ^WDT_CYC;
    assign bus.timeout  = 1'b0;
`endif

    assign bus.n_reset_out = r_out;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_seq
// Brief    : Directed and randomized bench for reset_seq against a phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq;
    localparam int NOUT      = 3;
    localparam int NREADY    = 1;
    localparam int DEB_CYC   = 4;
    localparam int HOLD_CYC  = 4;
    localparam int STAGE_CYC = 3;
    localparam int WDT_CYC   = 20;
`ifdef RESET_SEQ_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif
    localparam int PH_RESET = 0;
    localparam int PH_HOLD  = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_STAGE = 3;
    localparam int PH_RUN   = 4;

    logic clkSYS  = 1'b0;
    logic n_reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done     = 1'b0;

    reset_seq_if #(.NOUT(NOUT), .NREADY(NREADY)) bus ();

    reset_seq #(
        .NOUT(NOUT), .NREADY(NREADY), .DEB_CYC(DEB_CYC),
        .HOLD_CYC(HOLD_CYC), .STAGE_CYC(STAGE_CYC), .WDT_CYC(WDT_CYC)
    ) u_dut (
        .clkSYS  (clkSYS),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clkSYS = ~clkSYS;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: released-domain count plus time spent in the current phase.
    bit m_key_q[$];
    bit m_rdy_q[$];
    bit m_deb, m_to;
    int m_run, m_rel, m_timer, m_wdt, m_phase;

    task automatic model_init();
        m_key_q = '{1'b1, 1'b1};
        m_rdy_q = '{1'b0, 1'b0};
        m_deb = 1'b1; m_to = 1'b0;
        m_run = 0; m_rel = 0; m_timer = 0; m_wdt = 0; m_phase = PH_RESET;
    endtask

    task automatic model_step(input bit k, input bit r);
        bit ks, rs, deb_used;
        m_key_q.push_front(k); ks = m_key_q[2]; void'(m_key_q.pop_back());
        m_rdy_q.push_front(r); rs = m_rdy_q[2]; void'(m_rdy_q.pop_back());
        deb_used = m_deb;
        if (ks != m_deb) begin
            m_run++;
            if (m_run == DEB_CYC) begin m_deb = ks; m_run = 0; end
        end else begin
            m_run = 0;
        end
        if (!deb_used) begin
            m_phase = PH_RESET; m_rel = 0;
        end else begin
            case (m_phase)
                PH_RESET: begin m_phase = PH_HOLD; m_timer = 0; m_rel = 0; end
                PH_HOLD: begin
                    m_timer++;
                    if (m_timer == HOLD_CYC) begin m_phase = PH_WAIT; m_rel = 1; m_wdt = 0; end
                end
                PH_WAIT: begin
                    if (rs) begin
                        m_rel = 2; m_timer = 0;
                        m_phase = (m_rel == NOUT) ? PH_RUN : PH_STAGE;
                    end else if (WDT_EN) begin
                        m_wdt++;
                        if (m_wdt == WDT_CYC) begin m_to = 1'b1; m_phase = PH_RESET; m_rel = 0; end
                    end
                end
                PH_STAGE: begin
                    if (!rs) begin
                        m_rel = 1; m_phase = PH_WAIT; m_wdt = 0;
                    end else begin
                        m_timer++;
                        if (m_timer == STAGE_CYC) begin
                            m_rel++; m_timer = 0;
                            if (m_rel == NOUT) m_phase = PH_RUN;
                        end
                    end
                end
                default: if (!rs) begin m_rel = 1; m_phase = PH_WAIT; m_wdt = 0; end
            endcase
        end
    endtask

    always @(posedge clkSYS) begin
        if (!n_reset) model_init();
        else model_step(bus.key_n, &bus.ready);
    end

    always @(negedge clkSYS) begin
        logic [31:0] eo, eb, et;
        if (!done) begin
            if (!n_reset) begin
                eo = 0; eb = 1; et = 0;
            end else begin
                eo = (32'd1 << m_rel) - 32'd1;
                eb = (m_phase != PH_RUN) ? 32'd1 : 32'd0;
                et = {31'd0, m_to};
            end
            check("model_out", bus.n_reset_out, eo);
            check("model_busy", bus.busy, eb);
            check("model_timeout", bus.timeout, et);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clkSYS);
    endtask

    task automatic pulse_reset();
        @(posedge clkSYS);
        #2 n_reset = 1'b0;
        repeat (2) @(posedge clkSYS);
        @(negedge clkSYS);
        n_reset = 1'b1;
    endtask

    initial begin
        int key_left;
        bus.key_n = 1'b1;
        bus.ready = '0;
        // 1: power-up, ready low
        cycles(3);
        check("rst_out", bus.n_reset_out, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_timeout", bus.timeout, 0);
        n_reset = 1'b1;
        cycles(4);  check("t1_hold_len", bus.n_reset_out, 0);
        cycles(1);  check("t1_mem_rel", bus.n_reset_out, 1);
        cycles(WDT_EN ? 12 : 100);
        check("t1_stay_out", bus.n_reset_out, 1);
        check("t1_stay_busy", bus.busy, 1);
        // 2: ready rises
        bus.ready = '1;
        cycles(2);  check("t2_pre", bus.n_reset_out, 1);
        cycles(1);  check("t2_stage1", bus.n_reset_out, 3);
        cycles(2);  check("t2_gap", bus.n_reset_out, 3);
        cycles(1);  check("t2_run_out", bus.n_reset_out, 7);
        check("t2_run_busy", bus.busy, 0);
        // 3: key glitch, then a real press
        bus.key_n = 1'b0; cycles(3); bus.key_n = 1'b1;
        cycles(20); check("t3_glitch", bus.n_reset_out, 7);
        bus.key_n = 1'b0;
        cycles(6);  check("t3_press_pre", bus.n_reset_out, 7);
        cycles(1);  check("t3_press_out", bus.n_reset_out, 0);
        check("t3_press_busy", bus.busy, 1);
        cycles(3);  bus.key_n = 1'b1;
        cycles(40); check("t3_reseq", bus.n_reset_out, 7);
        // 4: ready loss in RUN
        bus.ready = '0;
        cycles(2);  check("t4_pre", bus.n_reset_out, 7);
        cycles(1);  check("t4_drop", bus.n_reset_out, 1);
        bus.ready = '1;
        cycles(3);  check("t4_s1", bus.n_reset_out, 3);
        cycles(2);  check("t4_gap", bus.n_reset_out, 3);
        cycles(1);  check("t4_s2", bus.n_reset_out, 7);
        // 5: key press coincides with ready rise in WAIT_RDY
        bus.ready = '0;
        pulse_reset();
        cycles(10);
        bus.key_n = 1'b0;
        cycles(4);
        bus.ready = '1;
        cycles(2);  check("t5_wait", bus.n_reset_out, 1);
        cycles(1);  check("t5_key_wins", bus.n_reset_out, 0);
        check("t5_busy", bus.busy, 1);
        bus.key_n = 1'b1;
        cycles(30); check("t5_reseq", bus.n_reset_out, 7);
        // 6: ready never arrives, then async reset mid-STAGE
        bus.ready = '0;
        pulse_reset();
        cycles(24);
        check("t6_pre_out", bus.n_reset_out, 1);
        check("t6_pre_to", bus.timeout, 0);
        cycles(1);
        check("t6_wdt_out", bus.n_reset_out, WDT_EN ? 0 : 1);
        check("t6_wdt_to", bus.timeout, WDT_EN ? 1 : 0);
        cycles(5);
        check("t6_retry_out", bus.n_reset_out, 1);
        check("t6_retry_to", bus.timeout, WDT_EN ? 1 : 0);
        bus.ready = '1;
        cycles(4);  check("t6_stage", bus.n_reset_out, 3);
        @(posedge clkSYS);
        #2 n_reset = 1'b0;
        #1;
        check("t6_async_out", bus.n_reset_out, 0);
        check("t6_async_to", bus.timeout, 0);
        check("t6_async_busy", bus.busy, 1);
        repeat (2) @(posedge clkSYS);
        @(negedge clkSYS);
        n_reset = 1'b1;
        // Randomized traffic against the model
        key_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clkSYS);
            if (key_left > 0) begin
                key_left--;
                if (key_left == 0) bus.key_n = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                bus.key_n = 1'b0;
                key_left  = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 29) == 0) bus.ready = ~bus.ready;
            if ($urandom_range(0, 799) == 0) pulse_reset();
        end
        cycles(2);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
